// File: rtl/pll_rst_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
// The state enum and the default parameter values live here.
package pll_rst_pkg;

  typedef enum logic [1:0] {
    PllRst   = 2'd0,
    WaitLock = 2'd1,
    Stable   = 2'd2,
    Run      = 2'd3
  } pll_rst_state_t;

  localparam int unsigned DefPllRstCycles = 16;
  localparam int unsigned DefLockTimeout  = 50000;
  localparam int unsigned DefLockStable   = 1024;
  localparam int unsigned DefSyncStages   = 2;
  localparam int unsigned DefRetryW       = 8;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cdc_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// Resets asynchronously to 0.
module cdc_bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses the PLL reset, qualifies lock with a timeout/retry
// and a stability window, then releases the system reset.
module pll_rst_seq
  import pll_rst_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = DefPllRstCycles,
  parameter int unsigned LOCK_TIMEOUT   = DefLockTimeout,
  parameter int unsigned LOCK_STABLE    = DefLockStable,
  parameter int unsigned SYNC_STAGES    = DefSyncStages,
  parameter int unsigned RETRY_W        = DefRetryW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_lock,
  input  logic               soft_rst,
  input  logic               clr_flags,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int unsigned CntMax = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] RstLast     = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE - 1);

  pll_rst_state_t     state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               lost_q, lost_d;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_rst_q, sys_rst_d;
  logic               ready_q, ready_d;
  logic               lock_s;
  logic               retry_inc;
  logic               lost_set;

  cdc_bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk(clk),
    .rst(rst),
    .d  (pll_lock),
    .q  (lock_s)
  );

  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    lost_set  = 1'b0;

    // soft_rst outranks everything, including lock loss in Run.
    if (soft_rst) begin
      state_d = PllRst;
    end else begin
      unique case (state_q)
        PllRst: begin
          if (cnt_q == RstLast) state_d = WaitLock;
        end
        WaitLock: begin
          if (lock_s) begin
            state_d = Stable;
          end else if (cnt_q == TimeoutLast) begin
            state_d   = PllRst;
            retry_inc = 1'b1;
          end
        end
        Stable: begin
          if (!lock_s) begin
            state_d = WaitLock;
          end else if (cnt_q == StableLast) begin
            state_d = Run;
          end
        end
        Run: begin
          if (!lock_s) begin
            state_d  = PllRst;
            lost_set = 1'b1;
          end
        end
        default: state_d = PllRst;
      endcase
    end

    // soft_rst restarts the count even when already in PllRst.
    if (soft_rst || (state_d != state_q)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end

    retry_d = retry_q;
    if (retry_inc && !(&retry_q)) retry_d = retry_q + RETRY_W'(1);

    // A new loss wins over a simultaneous clear.
    if (lost_set) begin
      lost_d = 1'b1;
    end else if (clr_flags) begin
      lost_d = 1'b0;
    end else begin
      lost_d = lost_q;
    end

    pll_rst_d = (state_d == PllRst);
    sys_rst_d = (state_d != Run);
    ready_d   = (state_d == Run);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PllRst;
      cnt_q     <= '0;
      retry_q   <= '0;
      lost_q    <= 1'b0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      lost_q    <= lost_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign lock_lost = lost_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against an elapsed-time model.
module tb_pll_rst_seq;

  localparam int unsigned PRC = 4;
  localparam int unsigned TO  = 20;
  localparam int unsigned ST  = 8;
  localparam int unsigned SS  = 2;
  localparam int unsigned RW  = 2;

  localparam logic [5:0] MP   = 6'b100000;
  localparam logic [5:0] MS   = 6'b010000;
  localparam logic [5:0] MR   = 6'b001000;
  localparam logic [5:0] ML   = 6'b000100;
  localparam logic [5:0] MC   = 6'b000011;
  localparam logic [5:0] MALL = 6'b111111;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pll_lock = 1'b0;
  logic          soft_rst = 1'b0;
  logic          clr_flags = 1'b0;
  logic          pll_rst;
  logic          sys_rst;
  logic          ready;
  logic          lock_lost;
  logic [RW-1:0] retry_cnt;

  always #5 clk = ~clk;

  pll_rst_seq #(
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT  (TO),
    .LOCK_STABLE   (ST),
    .SYNC_STAGES   (SS),
    .RETRY_W       (RW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pll_lock (pll_lock),
    .soft_rst (soft_rst),
    .clr_flags(clr_flags),
    .pll_rst  (pll_rst),
    .sys_rst  (sys_rst),
    .ready    (ready),
    .lock_lost(lock_lost),
    .retry_cnt(retry_cnt)
  );

  // Model: phase 0 = PLL held in reset, 1 = awaiting lock, 2 = qualifying, 3 = running.
  // Time in phase is measured as elapsed edges since the phase was entered.
  int            m_phase;
  longint        m_cyc;
  longint        m_start;
  logic [SS-1:0] m_pipe;
  logic [RW-1:0] m_retry;
  logic          m_lost;

  function automatic int model_next(input int ph, input logic lk, input longint el);
    case (ph)
      0:       return (el >= PRC - 1) ? 1 : 0;
      1:       return lk ? 2 : ((el >= TO - 1) ? 0 : 1);
      2:       return !lk ? 1 : ((el >= ST - 1) ? 3 : 2);
      default: return lk ? 3 : 0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_cyc   <= 0;
      m_start <= 0;
      m_pipe  <= '0;
      m_retry <= '0;
      m_lost  <= 1'b0;
    end else begin
      m_cyc  <= m_cyc + 1;
      m_pipe <= {m_pipe[SS-2:0], pll_lock};
      if (soft_rst) begin
        m_phase <= 0;
        m_start <= m_cyc + 1;
        if (clr_flags) m_lost <= 1'b0;
      end else begin
        if (model_next(m_phase, m_pipe[SS-1], m_cyc - m_start) != m_phase)
          m_start <= m_cyc + 1;
        m_phase <= model_next(m_phase, m_pipe[SS-1], m_cyc - m_start);
        if (m_phase == 1 && !m_pipe[SS-1] && (m_cyc - m_start) >= TO - 1 &&
            m_retry != {RW{1'b1}})
          m_retry <= m_retry + 1'b1;
        if (m_phase == 3 && !m_pipe[SS-1]) m_lost <= 1'b1;
        else if (clr_flags) m_lost <= 1'b0;
      end
    end
  end

  logic [5:0] dut_v;
  logic [5:0] mdl_v;
  assign dut_v = {pll_rst, sys_rst, ready, lock_lost, retry_cnt};
  assign mdl_v = {m_phase == 0, m_phase != 3, m_phase == 3, m_lost, m_retry};

  // Literal expectations posted by the stimulus process.
  logic       lit_valid = 1'b0;
  logic [5:0] lit_exp   = '0;
  logic [5:0] lit_care  = '0;
  string      lit_name  = "";

  int n_cmp = 0;
  int n_bad = 0;

  always @(negedge clk) begin
    n_cmp <= n_cmp + 1 + int'(lit_valid);
    n_bad <= n_bad + int'(dut_v !== mdl_v) +
             int'(lit_valid && ((dut_v & lit_care) !== (lit_exp & lit_care)));
    if (dut_v !== mdl_v)
      $display("FAIL model_cycle t=%0t got=%b want=%b (pll_rst,sys_rst,ready,lost,retry)",
               $time, dut_v, mdl_v);
    if (lit_valid && ((dut_v & lit_care) !== (lit_exp & lit_care)))
      $display("FAIL %s t=%0t got=%b want=%b care=%b", lit_name, $time, dut_v, lit_exp,
               lit_care);
  end

  task automatic adv();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_next(input string nm, input logic [5:0] e, input logic [5:0] c);
    lit_name  = nm;
    lit_exp   = e;
    lit_care  = c;
    lit_valid = 1'b1;
    adv();
    lit_valid = 1'b0;
  endtask

  task automatic wait_ready(input string nm);
    for (int i = 0; i < 60; i++) begin
      if (ready) break;
      adv();
    end
    expect_next(nm, MR, MR);
  endtask

  int hold;

  initial begin
    #1 rst = 1'b1;
    repeat (3) adv();
    expect_next("reset_state", 6'b110000, MALL);
    rst = 1'b0;

    // Nominal: lock sampled at edge 10, release at edge 20.
    expect_next("nom_prst_e1", MP, MP);
    adv();
    expect_next("nom_prst_e3", MP, MP);
    expect_next("nom_prst_e4", 6'b000000, MP);
    repeat (5) adv();
    pll_lock = 1'b1;
    repeat (9) adv();
    expect_next("nom_notready_e19", 6'b010000, MP | MS | MR);
    expect_next("nom_run_e20", 6'b001000, MALL);

    // Lock loss in Run: outputs react on the third edge.
    pll_lock = 1'b0;
    adv();
    expect_next("loss_e2", 6'b001000, MS | MR);
    expect_next("loss_e3", 6'b110100, MALL);
    pll_lock = 1'b1;
    wait_ready("relock_run");
    clr_flags = 1'b1;
    expect_next("clr_lost", 6'b001000, MR | ML);
    clr_flags = 1'b0;

    // Second loss with clr_flags on the same edge as the set.
    pll_lock = 1'b0;
    adv();
    adv();
    clr_flags = 1'b1;
    expect_next("loss_clr_same", 6'b110100, MP | MS | MR | ML);
    clr_flags = 1'b0;
    pll_lock = 1'b1;
    wait_ready("relock_run2");
    clr_flags = 1'b1;
    expect_next("clr_lost2", 6'b001000, MR | ML);
    clr_flags = 1'b0;

    // soft_rst in Run; lock then stays low to exercise timeouts.
    soft_rst = 1'b1;
    pll_lock = 1'b0;
    expect_next("soft_run", 6'b110000, MALL);
    soft_rst = 1'b0;
    repeat (22) adv();
    expect_next("to1_before", 6'b000000, MP | MC);
    expect_next("to1", 6'b110001, MALL);
    repeat (23) adv();
    expect_next("to2", 6'b110010, MALL);
    repeat (23) adv();
    expect_next("to3", 6'b110011, MALL);
    repeat (47) adv();
    expect_next("to5_sat", 6'b110011, MALL);

    // Glitch while qualifying: window restarts after the new lock_s rise.
    pll_lock = 1'b1;
    repeat (7) adv();
    pll_lock = 1'b0;
    repeat (3) adv();
    pll_lock = 1'b1;
    repeat (2) adv();
    expect_next("glitch_old_window", 6'b010000, MP | MS | MR);
    repeat (6) adv();
    expect_next("glitch_not_yet", 6'b010000, MS | MR);
    expect_next("glitch_release", 6'b001000, MP | MS | MR);

    // rst mid-Stable must act without a clock edge.
    soft_rst = 1'b1;
    adv();
    soft_rst = 1'b0;
    repeat (7) adv();
    @(posedge clk);
    #2 rst = 1'b1;
    expect_next("rst_async", 6'b110000, MALL);
    adv();
    rst = 1'b0;

    // Randomized run.
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        pll_lock = ~pll_lock;
        hold = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 3))
                                          : int'($urandom_range(10, 60));
      end
      hold--;
      soft_rst  = ($urandom_range(0, 199) == 0);
      clr_flags = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 799) == 0);
      adv();
    end
    soft_rst  = 1'b0;
    clr_flags = 1'b0;
    rst       = 1'b0;
    adv();
    adv();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
